serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes DIGIT bits per clock through a registered carry chain. It is the sequential successor to the single-bit full-adder block. It takes WIDTH-bit operands through a start/ready handshake and reports sum, carry-out and signed overflow with a one-cycle done pulse. It is used wherever area matters more than latency, for example in datapath helpers and ALU experiments.

---
 rtl/serial_adder.sv | 154 +++++++++++++++
 tb/tb_serial_adder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor. It handles DIGIT bits per clock
// and keeps the carry in a register between digits.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     begin an operation; sampled only while ready=1
//   sub       0 = a+b, 1 = a-b; captured with start
//   a, b      WIDTH-bit operands; captured with start
//   ready     idle; will accept start
//   done      one-cycle pulse; sum/cout/overflow are valid from this cycle
//   sum       registered result, modulo 2^WIDTH
//   cout      carry out of the MSB (for sub, 1 = no borrow)
//   overflow  two's-complement signed overflow
//
// state  | meaning
// S_IDLE | waiting for start, ready=1
// S_RUN  | one digit processed per clock, N clocks in total
// S_DONE | results just updated, done=1 for one cycle
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = $clog2(N) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [DIGIT:0]         dig_sum;
   logic                   c_msb_in;
   logic                   last_dig;
   logic [WIDTH+DIGIT-1:0] res_cat;
   logic [WIDTH-1:0]       res_next;

   // Digit adder. The carry into the digit's top bit comes from sum ^ a ^ b
   // at that bit. This avoids slicing below bit 0 when DIGIT = 1.
   always_comb begin
      dig_sum  = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};
      c_msb_in = dig_sum[DIGIT-1] ^ op_a_q[DIGIT-1] ^ op_b_q[DIGIT-1];
      last_dig = (cnt_q == CNT_W'(N - 1));
      // Each new digit enters at the MSB side. After N digits the result is LSB-aligned.
      res_cat  = {dig_sum[DIGIT-1:0], res_q};
      res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)    state_d = S_RUN;
         S_RUN:   if (last_dig) state_d = S_DONE;
         S_DONE:                state_d = S_IDLE;
         default:               state_d = S_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      ready = (state_q == S_IDLE);
      done  = (state_q == S_DONE);
   end

   // datapath next-state
   always_comb begin
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_a_d  = a;
               op_b_d  = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            op_a_d  = op_a_q >> DIGIT;
            op_b_d  = op_b_q >> DIGIT;
            res_d   = res_next;
            carry_d = dig_sum[DIGIT];
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_dig) begin
               sum_d  = res_next;
               cout_d = dig_sum[DIGIT];
               ovf_d  = c_msb_in ^ dig_sum[DIGIT];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sub = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [2:0] start_v = '0;
   logic [2:0] ready_v, done_v, cout_v, ovf_v;
   logic [2:0][7:0] sum_v;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   // index 0: DIGIT=1, index 1: DIGIT=4, index 2: DIGIT=8
   serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
      .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub), .a(a), .b(b),
      .ready(ready_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]),
      .overflow(ovf_v[0]));
   serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
      .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub), .a(a), .b(b),
      .ready(ready_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]),
      .overflow(ovf_v[1]));
   serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
      .clk(clk), .reset(reset), .start(start_v[2]), .sub(sub), .a(a), .b(b),
      .ready(ready_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]),
      .overflow(ovf_v[2]));

   typedef struct {
      int         k;
      logic       s;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] e_sum;
      logic       e_cout;
      logic       e_ovf;
      int         e_lat;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference model built from the integer definitions of add and subtract.
   task automatic model(input logic s, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] r, output logic c, output logic v);
      int ux, uy, sx, sy, ur, sr;
      ux = int'(x); uy = int'(y);
      sx = (ux > 127) ? ux - 256 : ux;
      sy = (uy > 127) ? uy - 256 : uy;
      if (s) begin
         ur = ux - uy;
         c  = (ux >= uy);
         sr = sx - sy;
      end else begin
         ur = ux + uy;
         c  = (ur > 255);
         sr = sx + sy;
      end
      r = 8'(ur & 255);
      v = (sr > 127) || (sr < -128);
   endtask

   // Latency counts rising edges from the start-sampling edge through the edge
   // after which done is seen.
   task automatic do_op(input int k, input logic s, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic [7:0] r, output logic c, output logic v,
                        output logic held);
      logic [7:0] prev;
      int w;
      w = 0;
      while (!ready_v[k] && w < 40) begin @(posedge clk); #1; w++; end
      if (!ready_v[k]) chk("ready_timeout", 32'(ready_v[k]), 32'd1);
      prev = sum_v[k];
      held = 1'b1;
      sub = s; a = x; b = y; start_v[k] = 1'b1;
      @(posedge clk); #1;
      start_v[k] = 1'b0; sub = $urandom_range(1); a = 8'($urandom); b = 8'($urandom);
      lat = 1;
      while (!done_v[k] && lat < 40) begin
         if (sum_v[k] !== prev) held = 1'b0;
         @(posedge clk); #1; lat++;
      end
      if (!done_v[k]) chk("done_timeout", 32'(done_v[k]), 32'd1);
      r = sum_v[k]; c = cout_v[k]; v = ovf_v[k];
   endtask

   initial begin
      int lat, cnt;
      logic [7:0] r, er;
      logic c, v, ec, ev, held;
      logic ss;
      logic [7:0] xx, yy;

      tbl.push_back('{0, 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 9});
      tbl.push_back('{0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 9});
      tbl.push_back('{0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 9});
      tbl.push_back('{0, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 9});
      tbl.push_back('{0, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 9});
      tbl.push_back('{1, 1'b0, 8'h9C, 8'h87, 8'h23, 1'b1, 1'b1, 3});
      tbl.push_back('{2, 1'b0, 8'h9C, 8'h87, 8'h23, 1'b1, 1'b1, 2});
      tbl.push_back('{1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 3});
      tbl.push_back('{2, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 2});

      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", 32'(ready_v[k]), 32'd1);
         chk("rst_done", 32'(done_v[k]), 32'd0);
         chk("rst_sum", 32'(sum_v[k]), 32'd0);
         chk("rst_cout_ovf", {30'd0, cout_v[k], ovf_v[k]}, 32'd0);
      end
      reset = 1'b0;
      @(posedge clk); #1;

      // directed vectors
      foreach (tbl[i]) begin
         do_op(tbl[i].k, tbl[i].s, tbl[i].x, tbl[i].y, lat, r, c, v, held);
         chk("vec_sum", 32'(r), 32'(tbl[i].e_sum));
         chk("vec_cout", 32'(c), 32'(tbl[i].e_cout));
         chk("vec_ovf", 32'(v), 32'(tbl[i].e_ovf));
         chk("vec_latency", 32'(lat), 32'(tbl[i].e_lat));
         chk("vec_hold", 32'(held), 32'd1);
         @(posedge clk); #1;
         chk("vec_ready_after", 32'(ready_v[tbl[i].k]), 32'd1);
         chk("vec_done_pulse", 32'(done_v[tbl[i].k]), 32'd0);
      end

      // busy protection: a second start during RUN must be ignored
      sub = 1'b0; a = 8'h10; b = 8'h20; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      a = 8'hAA; b = 8'h55; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0; a = 8'h00; b = 8'h00;
      cnt = 0;
      while (!done_v[0] && cnt < 40) begin @(posedge clk); #1; cnt++; end
      chk("busy_done_seen", 32'(done_v[0]), 32'd1);
      chk("busy_sum", 32'(sum_v[0]), 32'h30);
      chk("busy_elapsed", 32'(cnt), 32'd5);
      @(posedge clk); #1;
      chk("busy_ready", 32'(ready_v[0]), 32'd1);
      do_op(0, 1'b0, 8'h01, 8'h01, lat, r, c, v, held);
      chk("busy_second_sum", 32'(r), 32'h02);
      chk("busy_second_lat", 32'(lat), 32'd9);

      // randomized operations against the reference model
      for (int i = 0; i < 60; i++) begin
         int k;
         k = (i < 36) ? 0 : ((i < 48) ? 1 : 2);
         ss = $urandom_range(1); xx = 8'($urandom); yy = 8'($urandom);
         do_op(k, ss, xx, yy, lat, r, c, v, held);
         model(ss, xx, yy, er, ec, ev);
         chk("rnd_result", {23'd0, r, c}, {23'd0, er, ec});
         chk("rnd_ovf", 32'(v), 32'(ev));
         chk("rnd_lat", 32'(lat), (k == 0) ? 32'd9 : ((k == 1) ? 32'd3 : 32'd2));
         chk("rnd_hold", 32'(held), 32'd1);
      end

      // reset abort in the middle of RUN
      do_op(0, 1'b1, 8'h80, 8'h01, lat, r, c, v, held);
      chk("pre_abort", {23'd0, r, c}, {23'd0, 8'h7F, 1'b1});
      @(posedge clk); #1;
      sub = 1'b0; a = 8'h35; b = 8'h4A; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("abort_ready", 32'(ready_v[0]), 32'd1);
      chk("abort_sum", 32'(sum_v[0]), 32'd0);
      chk("abort_cout_ovf", {30'd0, cout_v[0], ovf_v[0]}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done_v[0]) cnt++;
      end
      chk("abort_no_done", 32'(cnt), 32'd0);
      do_op(0, 1'b0, 8'h01, 8'h02, lat, r, c, v, held);
      chk("abort_next_sum", 32'(r), 32'h03);
      chk("abort_next_lat", 32'(lat), 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
